// File: rtl/vr16_pkg.sv
// Shared types and encodings for the VR16 frontend control path.
package vr16_pkg;

  typedef enum logic [2:0] {
    ST_FETCH   = 3'b000,
    ST_DECODE  = 3'b001,
    ST_EXECUTE = 3'b010,
    ST_WRITE   = 3'b011,
    ST_JUMP    = 3'b100,
    ST_MEM     = 3'b101,
    ST_FAULT   = 3'b110,
    ST_HALT    = 3'b111
  } state_t;

  localparam logic [3:0] OP_LOAD  = 4'b1000;
  localparam logic [3:0] OP_JUMP  = 4'b1001;
  localparam logic [3:0] OP_STORE = 4'b1010;
  localparam logic [3:0] OP_HALT  = 4'b1111;

  localparam logic [1:0] SEL_REG  = 2'b00;
  localparam logic [1:0] SEL_IMM  = 2'b01;
  localparam logic [1:0] SEL_ADDR = 2'b10;

  typedef enum logic [2:0] {
    OPC_ALU_REG,
    OPC_ALU_IMM,
    OPC_LOAD,
    OPC_STORE,
    OPC_JUMP,
    OPC_HALT
  } op_class_t;

  // ALU-imm group is 0001/0011/0101/0111; every opcode not named elsewhere is ALU-reg.
  function automatic op_class_t classify(input logic [3:0] op);
    case (op)
      4'b0001, 4'b0011, 4'b0101, 4'b0111: return OPC_ALU_IMM;
      OP_LOAD:  return OPC_LOAD;
      OP_STORE: return OPC_STORE;
      OP_JUMP:  return OPC_JUMP;
      OP_HALT:  return OPC_HALT;
      default:  return OPC_ALU_REG;
    endcase
  endfunction

endpackage

// File: rtl/control_unit_mc_wait_timer.sv
// Acknowledge wait counter; expired flags the LIMIT-th consecutive un-acked cycle.
module wait_timer #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned LIMIT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int unsigned LAST = (LIMIT > 0) ? LIMIT - 1 : 0;

  logic [WIDTH-1:0] count;

  // A LIMIT of zero disables the timeout entirely.
  assign expired = (LIMIT > 0) && (32'(count) == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (run && !expired) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/control_unit_mc.sv
// VR16 multicycle control unit: fetch/decode/execute sequencer with acked waits,
// load/store sequencing, resumable halt and a sticky fault.
module control_unit_mc
  import vr16_pkg::*;
#(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned REG_ADDR_W = 2,
  parameter int unsigned PC_W       = 16,
  parameter int unsigned WAIT_LIMIT = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fetch_valid,
  input  logic                  alu_done,
  input  logic                  mem_ready,
  input  logic                  jump_done,
  input  logic                  resume,
  input  logic [3:0]            opcode,
  input  logic [REG_ADDR_W-1:0] store_at,
  input  logic [REG_ADDR_W-1:0] operand_one,
  input  logic [REG_ADDR_W-1:0] operand_two,
  input  logic [DATA_W-1:0]     immediate_value,
  input  logic [PC_W-1:0]       jump_address,
  output logic                  fetch_req,
  output logic                  enable_alu,
  output logic                  enable_reg_write,
  output logic                  enable_pc_increment,
  output logic                  enable_jump,
  output logic                  mem_req,
  output logic                  mem_write,
  output logic [1:0]            select_operation,
  output logic                  write_src,
  output logic [REG_ADDR_W-1:0] reg_write_address,
  output logic [REG_ADDR_W-1:0] reg_read_address_one,
  output logic [REG_ADDR_W-1:0] reg_read_address_two,
  output logic [DATA_W-1:0]     operand_two_out,
  output logic [PC_W-1:0]       jump_address_out,
  output logic                  halted,
  output logic                  fault,
  output logic [2:0]            state_out
);

  localparam int unsigned TIMER_W = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;

  state_t                state, state_next;
  logic [3:0]            opcode_q;
  logic [REG_ADDR_W-1:0] store_at_q, op_one_q, op_two_q;
  logic [DATA_W-1:0]     imm_q;
  logic [PC_W-1:0]       jump_q;
  op_class_t             op_class;
  logic                  timer_run, timer_clear, timer_expired;

  assign op_class  = classify(opcode_q);
  assign state_out = state;

  wait_timer #(
    .WIDTH (TIMER_W),
    .LIMIT (WAIT_LIMIT)
  ) u_wait_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (timer_clear),
    .run     (timer_run),
    .expired (timer_expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_FETCH;
    end else begin
      state <= state_next;
    end
  end

  // Decoder fields are captured once per instruction; outputs never see live decoder inputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      opcode_q   <= '0;
      store_at_q <= '0;
      op_one_q   <= '0;
      op_two_q   <= '0;
      imm_q      <= '0;
      jump_q     <= '0;
    end else if (state == ST_FETCH && fetch_valid) begin
      opcode_q   <= opcode;
      store_at_q <= store_at;
      op_one_q   <= operand_one;
      op_two_q   <= operand_two;
      imm_q      <= immediate_value;
      jump_q     <= jump_address;
    end
  end

  always_comb begin
    state_next           = state;
    timer_run            = 1'b0;
    fetch_req            = 1'b0;
    enable_alu           = 1'b0;
    enable_reg_write     = 1'b0;
    enable_pc_increment  = 1'b0;
    enable_jump          = 1'b0;
    mem_req              = 1'b0;
    mem_write            = 1'b0;
    select_operation     = SEL_REG;
    write_src            = 1'b0;
    reg_write_address    = '0;
    reg_read_address_one = '0;
    reg_read_address_two = '0;
    operand_two_out      = '0;
    jump_address_out     = '0;
    halted               = 1'b0;
    fault                = 1'b0;

    // Everything stays quiet while reset is held, including the FETCH request.
    if (!reset) begin
      if (state != ST_FETCH) begin
        reg_write_address    = store_at_q;
        reg_read_address_one = op_one_q;
        reg_read_address_two = op_two_q;
        jump_address_out     = jump_q;
      end

      case (state)
        ST_FETCH: begin
          fetch_req = 1'b1;
          if (fetch_valid) state_next = ST_DECODE;
        end
        ST_DECODE: state_next = ST_EXECUTE;
        ST_EXECUTE: begin
          case (op_class)
            OPC_JUMP: state_next = ST_JUMP;
            OPC_HALT: state_next = ST_HALT;
            default: begin
              enable_alu = 1'b1;
              if (op_class == OPC_ALU_REG)      select_operation = SEL_REG;
              else if (op_class == OPC_ALU_IMM) select_operation = SEL_IMM;
              else                              select_operation = SEL_ADDR;
              if (select_operation != SEL_REG) operand_two_out = imm_q;
              if (alu_done) begin
                state_next = (op_class inside {OPC_LOAD, OPC_STORE}) ? ST_MEM : ST_WRITE;
              end else begin
                timer_run = 1'b1;
                if (timer_expired) state_next = ST_FAULT;
              end
            end
          endcase
        end
        ST_MEM: begin
          mem_req   = 1'b1;
          mem_write = (op_class == OPC_STORE);
          if (mem_ready) begin
            if (op_class == OPC_STORE) begin
              enable_pc_increment = 1'b1;
              state_next          = ST_FETCH;
            end else begin
              state_next = ST_WRITE;
            end
          end else begin
            timer_run = 1'b1;
            if (timer_expired) state_next = ST_FAULT;
          end
        end
        ST_WRITE: begin
          enable_reg_write    = 1'b1;
          enable_pc_increment = 1'b1;
          write_src           = (op_class == OPC_LOAD);
          state_next          = ST_FETCH;
        end
        ST_JUMP: begin
          enable_jump = 1'b1;
          if (jump_done) begin
            state_next = ST_FETCH;
          end else begin
            timer_run = 1'b1;
            if (timer_expired) state_next = ST_FAULT;
          end
        end
        ST_HALT: begin
          halted = 1'b1;
          if (resume) begin
            enable_pc_increment = 1'b1;
            state_next          = ST_FETCH;
          end
        end
        ST_FAULT: fault = 1'b1;
        default:  state_next = ST_FETCH;
      endcase
    end

    timer_clear = (state_next != state);
  end

endmodule

// File: tb/tb_control_unit_mc.sv
// Randomized bench for control_unit_mc: each instruction is expanded into a per-cycle
// schedule of expected outputs from the opcode, ack delays and timeout rule.
module tb_control_unit_mc;

  localparam int unsigned L = 15;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fetch_valid = 1'b0, alu_done = 1'b0, mem_ready = 1'b0, jump_done = 1'b0, resume = 1'b0;
  logic [3:0]  opcode = '0;
  logic [1:0]  store_at = '0, operand_one = '0, operand_two = '0;
  logic [15:0] immediate_value = '0, jump_address = '0;
  logic        fetch_req, enable_alu, enable_reg_write, enable_pc_increment, enable_jump;
  logic        mem_req, mem_write, write_src, halted, fault;
  logic [1:0]  select_operation, reg_write_address, reg_read_address_one, reg_read_address_two;
  logic [15:0] operand_two_out, jump_address_out;
  logic [2:0]  state_out;

  always #5 clk = ~clk;

  control_unit_mc #(
    .DATA_W(16), .REG_ADDR_W(2), .PC_W(16), .WAIT_LIMIT(L)
  ) dut (
    .clk(clk), .reset(reset), .fetch_valid(fetch_valid), .alu_done(alu_done),
    .mem_ready(mem_ready), .jump_done(jump_done), .resume(resume), .opcode(opcode),
    .store_at(store_at), .operand_one(operand_one), .operand_two(operand_two),
    .immediate_value(immediate_value), .jump_address(jump_address),
    .fetch_req(fetch_req), .enable_alu(enable_alu), .enable_reg_write(enable_reg_write),
    .enable_pc_increment(enable_pc_increment), .enable_jump(enable_jump),
    .mem_req(mem_req), .mem_write(mem_write), .select_operation(select_operation),
    .write_src(write_src), .reg_write_address(reg_write_address),
    .reg_read_address_one(reg_read_address_one), .reg_read_address_two(reg_read_address_two),
    .operand_two_out(operand_two_out), .jump_address_out(jump_address_out),
    .halted(halted), .fault(fault), .state_out(state_out)
  );

  typedef struct packed {
    logic [2:0]  st;
    logic        fetch_req, enable_alu, enable_reg_write, enable_pc_increment, enable_jump;
    logic        mem_req, mem_write;
    logic [1:0]  sel;
    logic        write_src;
    logic [1:0]  waddr, ra1, ra2;
    logic [15:0] op2, jaddr;
    logic        halted, fault;
  } obs_t;

  typedef struct packed {
    logic fv, ad, mr, jd, rs;
  } ctl_t;

  int   n_checks = 0;
  int   n_fail = 0;
  obs_t exp_q[$];
  ctl_t stim_q[$];
  int   valid_idx;

  int          cap_nf, cap_mreq, cap_halted, cap_pcmask;
  logic [15:0] cap_op2;
  logic [1:0]  cap_sel, cap_waddr;
  logic        cap_wsrc, cap_mwr, cap_regwr, cap_fault;

  function automatic obs_t dut_obs();
    obs_t o;
    o.st = state_out; o.fetch_req = fetch_req; o.enable_alu = enable_alu;
    o.enable_reg_write = enable_reg_write; o.enable_pc_increment = enable_pc_increment;
    o.enable_jump = enable_jump; o.mem_req = mem_req; o.mem_write = mem_write;
    o.sel = select_operation; o.write_src = write_src; o.waddr = reg_write_address;
    o.ra1 = reg_read_address_one; o.ra2 = reg_read_address_two; o.op2 = operand_two_out;
    o.jaddr = jump_address_out; o.halted = halted; o.fault = fault;
    return o;
  endfunction

  task automatic check(input obs_t exp, input string name);
    obs_t act;
    act = dut_obs();
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t state got %0d want %0d, outputs got %h want %h",
               name, $time, act.st, exp.st, act, exp);
    end
  endtask

  task automatic chk_lit(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // 0 ALU-reg, 1 ALU-imm, 2 LOAD, 3 STORE, 4 JUMP, 5 HALT
  function automatic int kind_of(input logic [3:0] op);
    case (op)
      4'b0001, 4'b0011, 4'b0101, 4'b0111: return 1;
      4'b1000: return 2;
      4'b1010: return 3;
      4'b1001: return 4;
      4'b1111: return 5;
      default: return 0;
    endcase
  endfunction

  function automatic ctl_t rnd_ctl();
    return ctl_t'(5'($urandom));
  endfunction

  function automatic ctl_t set_ack(input ctl_t c, input int w, input logic v);
    ctl_t r;
    r = c;
    case (w)
      0: r.ad = v;
      1: r.mr = v;
      2: r.jd = v;
      default: r.rs = v;
    endcase
    return r;
  endfunction

  task automatic push(input obs_t e, input ctl_t c);
    exp_q.push_back(e);
    stim_q.push_back(c);
  endtask

  // d ack-low cycles, then the ack; a timed wait gives up after L low cycles.
  task automatic push_wait(input obs_t e, input obs_t e_ack, input obs_t base, input int w,
                           input int d, input bit timed, output bit to);
    obs_t f;
    int   n_low;
    to    = timed && (d >= int'(L));
    n_low = to ? int'(L) : d;
    for (int k = 0; k < n_low; k++) push(e, set_ack(rnd_ctl(), w, 1'b0));
    if (to) begin
      f = base; f.st = 3'd6; f.fault = 1'b1;
      for (int k = 0; k < 3; k++) push(f, rnd_ctl());
    end else begin
      push(e_ack, set_ack(rnd_ctl(), w, 1'b1));
    end
  endtask

  task automatic build(input logic [3:0] op, input logic [1:0] sa, o1, o2,
                       input logic [15:0] imm, ja, input int fw, d1, d2, output bit to);
    obs_t base, e, e2;
    ctl_t c;
    int   k;
    exp_q.delete();
    stim_q.delete();
    to = 1'b0;
    k  = kind_of(op);
    for (int i = 0; i <= fw; i++) begin
      e = '0; e.fetch_req = 1'b1;
      c = rnd_ctl(); c.fv = (i == fw);
      push(e, c);
    end
    valid_idx = fw;
    base = '0; base.waddr = sa; base.ra1 = o1; base.ra2 = o2; base.jaddr = ja;
    e = base; e.st = 3'd1; push(e, rnd_ctl());
    e = base; e.st = 3'd2;
    if (k >= 4) begin
      push(e, rnd_ctl());
      e = base;
      if (k == 4) begin
        e.st = 3'd4; e.enable_jump = 1'b1;
        push_wait(e, e, base, 2, d1, 1'b1, to);
      end else begin
        e.st = 3'd7; e.halted = 1'b1;
        e2 = e; e2.enable_pc_increment = 1'b1;
        push_wait(e, e2, base, 3, d1, 1'b0, to);
      end
    end else begin
      e.enable_alu = 1'b1;
      e.sel = (k == 0) ? 2'd0 : (k == 1) ? 2'd1 : 2'd2;
      e.op2 = (k == 0) ? 16'h0000 : imm;
      push_wait(e, e, base, 0, d1, 1'b1, to);
      if (!to && k >= 2) begin
        e = base; e.st = 3'd5; e.mem_req = 1'b1; e.mem_write = (k == 3);
        e2 = e; e2.enable_pc_increment = (k == 3);
        push_wait(e, e2, base, 1, d2, 1'b1, to);
      end
      if (!to && k != 3) begin
        e = base; e.st = 3'd3; e.enable_reg_write = 1'b1; e.enable_pc_increment = 1'b1;
        e.write_src = (k == 2);
        push(e, rnd_ctl());
      end
    end
  endtask

  task automatic run(input logic [3:0] op, input logic [1:0] sa, o1, o2,
                     input logic [15:0] imm, ja, input int fw, d1, d2, input int abort_at,
                     output bit to);
    build(op, sa, o1, o2, imm, ja, fw, d1, d2, to);
    cap_nf = 0; cap_mreq = 0; cap_halted = 0; cap_pcmask = 0;
    cap_op2 = '0; cap_sel = '0; cap_waddr = '0;
    cap_wsrc = 1'b0; cap_mwr = 1'b0; cap_regwr = 1'b0; cap_fault = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      fetch_valid = stim_q[i].fv; alu_done = stim_q[i].ad; mem_ready = stim_q[i].mr;
      jump_done = stim_q[i].jd; resume = stim_q[i].rs;
      if (i == valid_idx) begin
        opcode = op; store_at = sa; operand_one = o1; operand_two = o2;
        immediate_value = imm; jump_address = ja;
      end else begin
        opcode = 4'($urandom); store_at = 2'($urandom); operand_one = 2'($urandom);
        operand_two = 2'($urandom); immediate_value = 16'($urandom);
        jump_address = 16'($urandom);
      end
      #1;
      check(exp_q[i], "cycle");
      if (state_out != 3'd0) cap_nf++;
      if (mem_req) cap_mreq++;
      if (halted) cap_halted++;
      if (state_out == 3'd2) begin cap_op2 = operand_two_out; cap_sel = select_operation; end
      if (enable_reg_write) begin cap_regwr = 1'b1; cap_waddr = reg_write_address; cap_wsrc = write_src; end
      if (mem_write) cap_mwr = 1'b1;
      if (fault) cap_fault = 1'b1;
      if (enable_pc_increment && i < 31) cap_pcmask |= (1 << i);
      if (i == abort_at) begin
        reset = 1'b1;
        #1;
        check('0, "reset_abort");
        break;
      end
    end
  endtask

  task automatic do_reset();
    obs_t e;
    @(negedge clk);
    reset = 1'b1; fetch_valid = 1'b0; alu_done = 1'b0; mem_ready = 1'b0;
    jump_done = 1'b0; resume = 1'b0;
    #1;
    check('0, "reset_zero");
    @(negedge clk);
    reset = 1'b0;
    #1;
    e = '0; e.fetch_req = 1'b1;
    check(e, "post_reset");
  endtask

  initial begin
    #100000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit to;
    int fw, d1, d2;
    #1;
    check('0, "reset_initial");
    do_reset();

    // ALU-reg, acks immediate: 4 cycles fetch-to-fetch, pc increment in cycle 4.
    run(4'b0000, 2'd2, 2'd1, 2'd3, 16'h1234, 16'h0, 0, 0, 0, -1, to);
    chk_lit("alu_reg_latency", cap_nf + 1, 4);
    chk_lit("alu_reg_waddr", int'(cap_waddr), 2);
    chk_lit("alu_reg_pc_pulse", cap_pcmask, 8);

    // ADDI with a slow ALU while decoder inputs churn.
    run(4'b0001, 2'd1, 2'd0, 2'd2, 16'h0005, 16'h0, 1, 2, 0, -1, to);
    chk_lit("addi_operand", int'(cap_op2), 5);
    chk_lit("addi_select", int'(cap_sel), 1);

    // LOAD with mem_ready three cycles late.
    run(4'b1000, 2'd3, 2'd1, 2'd0, 16'h0010, 16'h0, 0, 0, 3, -1, to);
    chk_lit("load_mem_req_cycles", cap_mreq, 4);
    chk_lit("load_latency", cap_nf + 1, 8);
    chk_lit("load_write_src", int'(cap_wsrc), 1);

    // STORE: memory write, no register write.
    run(4'b1010, 2'd0, 2'd2, 2'd1, 16'h0020, 16'h0, 0, 0, 0, -1, to);
    chk_lit("store_mem_write", int'(cap_mwr), 1);
    chk_lit("store_no_reg_write", int'(cap_regwr), 0);
    chk_lit("store_latency", cap_nf + 1, 4);

    // JUMP never acked: faults after L low cycles and stays there.
    run(4'b1001, 2'd0, 2'd0, 2'd0, 16'h0, 16'h0040, 0, int'(L), 0, -1, to);
    chk_lit("jump_timeout_fault", int'(cap_fault), 1);
    chk_lit("jump_fault_state", int'(state_out), 6);
    do_reset();

    // JUMP acked on the L-th cycle: no fault.
    run(4'b1001, 2'd0, 2'd0, 2'd0, 16'h0, 16'h0040, 0, int'(L) - 1, 0, -1, to);
    chk_lit("jump_late_ack_no_fault", int'(cap_fault), 0);
    chk_lit("jump_late_latency", cap_nf + 1, 18);

    // HALT held 20 cycles then resumed.
    run(4'b1111, 2'd1, 2'd2, 2'd3, 16'h0, 16'h0, 0, 20, 0, -1, to);
    chk_lit("halt_cycles", cap_halted, 21);
    chk_lit("halt_resume_pc", cap_pcmask, 1 << 23);

    // Reset in the middle of a LOAD's memory wait.
    run(4'b1000, 2'd3, 2'd2, 2'd1, 16'h00ff, 16'h0, 0, 0, 5, 4, to);
    do_reset();

    for (int n = 0; n < 60; n++) begin
      fw = ($urandom_range(0, 9) == 0) ? 17 : int'($urandom_range(0, 3));
      d1 = ($urandom_range(0, 7) == 0) ? int'($urandom_range(14, 17)) : int'($urandom_range(0, 4));
      d2 = ($urandom_range(0, 7) == 0) ? int'($urandom_range(14, 17)) : int'($urandom_range(0, 4));
      run(4'($urandom), 2'($urandom), 2'($urandom), 2'($urandom), 16'($urandom),
          16'($urandom), fw, d1, d2, -1, to);
      if (to) do_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/control_unit_mc.md
# control_unit_mc

Parametrised multicycle control unit for the VR16 frontend, generalising the base FETCH/DECODE/EXECUTE/WRITE/JUMP/HALT sequencer. Adds:

- a fetch handshake;
- ALU, memory and jump acknowledgements with a bounded wait;
- load/store sequencing;
- a resumable HALT;
- a sticky FAULT state.

It sits between the instruction decoder and the datapath (register file, ALU, data memory port, PC).

## Interface
Parameters:
- DATA_W, 16, immediate/operand width
- REG_ADDR_W, 2, register address width
- PC_W, 16, jump address width
- WAIT_LIMIT, 15, max cycles awaiting any acknowledge; 0 disables timeout

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- fetch_valid  in  1  instruction fields valid
- alu_done / mem_ready / jump_done  in  1  acknowledges
- resume  in  1  leave HALT
- opcode  in  4  decoded opcode
- store_at, operand_one, operand_two  in  REG_ADDR_W  register fields
- immediate_value  in  DATA_W; jump_address  in  PC_W
- fetch_req, enable_alu, enable_reg_write, enable_pc_increment, enable_jump, mem_req, mem_write  out  1
- select_operation  out  2  00 reg, 01 imm, 10 reg+imm (address)
- write_src  out  1  0 ALU result, 1 memory data
- reg_write_address, reg_read_address_one, reg_read_address_two  out  REG_ADDR_W
- operand_two_out  out  DATA_W  (immediate when select_operation is 01/10, else 0)
- jump_address_out  out  PC_W
- halted, fault  out  1
- state_out  out  3  current state encoding

## Operation
Opcodes:
- ALU-reg: 0000, 0010, 0100, 0110, 1011, 1100, 1101, 1110
- ALU-imm: 0001, 0011, 0101, 0111
- LOAD: 1000 (rd ← mem[rs1+imm])
- JUMP: 1001
- STORE: 1010 (mem[rs1+imm] ← rs2)
- HALT: 1111

States: FETCH=000, DECODE=001, EXECUTE=010, WRITE=011, JUMP=100, MEM=101, FAULT=110, HALT=111.

Transitions:
- FETCH: fetch_req=1; on fetch_valid, latch opcode/fields/immediate/jump_address into internal registers → DECODE.
- DECODE → EXECUTE unconditionally.
- EXECUTE:
  - ALU ops: enable_alu=1, select 00/01; on alu_done → WRITE.
  - LOAD/STORE: enable_alu=1, select 10; on alu_done → MEM.
  - JUMP → JUMP.
  - HALT → HALT.
- MEM: mem_req=1, mem_write=1 for STORE.
  - On mem_ready: LOAD → WRITE (write_src=1); STORE → FETCH with enable_pc_increment=1.
- WRITE: enable_reg_write=1, enable_pc_increment=1 for one cycle → FETCH.
- JUMP: enable_jump=1; on jump_done → FETCH (no PC increment).
- HALT: halted=1; on resume → FETCH with enable_pc_increment=1.
- FAULT: fault=1; no enables asserted; leaves only on reset.

Outputs:
- All outputs are driven combinationally from state and latched fields, never from live decoder inputs after FETCH.
- Address/data outputs are 0 while in FETCH.

Wait timer:
- Counts cycles spent in EXECUTE (ALU ops and LOAD/STORE), MEM or JUMP without the awaited ack.
- Cleared on every state change.
- If it reaches WAIT_LIMIT with the ack still low → FAULT.
- An ack on the same cycle as expiry wins.

## Timing
- Reset, async: state=FETCH, latched fields=0, counter=0. While reset is high every output is 0 and state_out=000.
- Minimum latency, acks in the same cycle they are awaited:
  - ALU op: 4 cycles fetch-to-fetch.
  - LOAD: 5 cycles.
  - STORE: 4 cycles.
  - JUMP: 4 cycles.
- Each extra ack-low cycle adds one cycle.
- Enables are single-cycle pulses except while waiting, where they are held high until the ack.
- fetch_valid low in FETCH: remain in FETCH indefinitely. FETCH is not timed.
- resume is ignored outside HALT.
- Acks are ignored outside their waiting state.
- Reset mid-operation aborts immediately: no write or increment pulse is emitted.

## Structure
- Package vr16_pkg holds:
  - state_t enum;
  - opcode constants and the ALU-reg/ALU-imm opcode groups;
  - SEL_REG/SEL_IMM/SEL_ADDR encodings.
- Sub-module wait_timer (params WIDTH, LIMIT; ports clk, reset, clear, run, expired) implements the timeout counter. Its width is $clog2(WAIT_LIMIT+1).

## Test plan
- ALU-reg 0000 store_at=2, alu_done tied high → state sequence 000,001,010,011,000; reg_write_address=2 and pc_increment pulse in cycle 4.
- ADDI 0001 imm=16'h0005 → select_operation=01, operand_two_out=0005 during EXECUTE; changing decoder inputs after FETCH does not alter outputs.
- LOAD, mem_ready delayed 3 cycles → mem_req high 4 cycles, WRITE with write_src=1, total 8 cycles. STORE → mem_write=1, returns to FETCH without enable_reg_write.
- JUMP jump_address=16'h0040, jump_done low for WAIT_LIMIT=15 cycles → FAULT, fault=1 sticky. A repeat run with jump_done on the 15th cycle → FETCH, no fault.
- HALT → halted=1 held for 20 cycles; resume pulse → FETCH next cycle with enable_pc_increment=1.
- Reset asserted during MEM → all outputs 0 immediately; after release, state=FETCH and fields=0.
